// File: rtl/load_cell_a2d.sv
// Round-robin A2D front end: SPI master to the 8-ch 12-bit ADC, one channel converted per nxt.
// Latency: about 1044 clk from nxt sampled in IDLE to the cnv_cmplt/result update (2 transfers + 2 clk gap).
// Backpressure: none; nxt outside IDLE is dropped, results held until that channel converts again.
module load_cell_a2d #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr;        // 0=LFT 1=RGHT 2=STEER 3=BATT
  logic        gap_cnt;
  logic [4:0]  div;
  logic [15:0] shreg;
  logic [4:0]  smpl_cnt;
  logic        miso_smpl;
  logic        spi_start;
  logic        spi_done;
  logic        wr_en;
  logic [2:0]  chnl;
  logic [15:0] cmd;
  logic [11:0] rx_word;

  assign SCLK = div[4];
  assign MOSI = shreg[15];
  assign cmd  = {2'b00, chnl, 11'h000};

  // The last received bit still sits in miso_smpl on the done clock, so splice it in here.
  assign rx_word  = {shreg[10:0], miso_smpl};
  assign spi_done = ~SS_n && (div == 5'b11111) && (smpl_cnt == 5'd16);

  // Map the round-robin pointer onto the ADC channel number.
  always_comb begin
    chnl = CH_LFT;
    case (ptr)
      2'd0: chnl = CH_LFT;
      2'd1: chnl = CH_RGHT;
      2'd2: chnl = CH_STEER;
      2'd3: chnl = CH_BATT;
      default: chnl = CH_LFT;
    endcase
  end

  // SPI mode 3 engine: sample on SCLK rise, shift on SCLK fall; the first fall only
  // opens the frame, and the final shift lands on the back-porch clock that ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n      <= 1'b1;
      div       <= 5'b11111;
      shreg     <= 16'h0000;
      smpl_cnt  <= 5'd0;
      miso_smpl <= 1'b0;
    end else if (spi_start) begin
      SS_n     <= 1'b0;
      div      <= 5'b10111;
      shreg    <= cmd;
      smpl_cnt <= 5'd0;
    end else if (!SS_n) begin
      if (div == 5'b01111) begin
        miso_smpl <= MISO;
        smpl_cnt  <= smpl_cnt + 5'd1;
      end
      if ((div == 5'b11111) && (smpl_cnt != 5'd0))
        shreg <= {shreg[14:0], miso_smpl};
      if (spi_done) begin
        SS_n <= 1'b1;
        div  <= 5'b11111;
      end else begin
        div <= div + 5'd1;
      end
    end
  end

  // Conversion sequencer state register and two-clock inter-transfer gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == GAP) ? ~gap_cnt : 1'b0;
    end
  end

  // Next-state logic: command transfer, gap, data transfer, then commit the result.
  always_comb begin
    state_nxt = state;
    spi_start = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: if (nxt) begin
        spi_start = 1'b1;
        state_nxt = XFER1;
      end
      XFER1: if (spi_done) state_nxt = GAP;
      GAP: if (gap_cnt) begin
        spi_start = 1'b1;
        state_nxt = XFER2;
      end
      XFER2: if (spi_done) begin
        wr_en     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commit the data-transfer result to the current channel and step the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 2'd0;
      cnv_cmplt <= 1'b0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      cnv_cmplt <= wr_en;
      if (wr_en) begin
        ptr <= ptr + 2'd1;
        case (ptr)
          2'd0: lft_ld    <= rx_word;
          2'd1: rght_ld   <= rx_word;
          2'd2: steer_pot <= rx_word;
          2'd3: batt      <= rx_word;
          default: lft_ld <= rx_word;
        endcase
      end
    end
  end

endmodule
